// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S stereo PCM transmitter with one-entry holding buffer
//
// Purpose:
//   Serializes left/right PCM sample pairs onto a standard I2S bus.
//   The block generates its own bit clock (sclk_out) and word select (ws_out)
//   from clk_in.
//   Each channel slot is FRAME_BITS/2 sclk periods wide. The sample MSB is
//   driven one sclk after the ws transition, left-justified in the slot, and
//   the rest of the slot is zero-padded.
//
// Ports:
//   clk_in       system clock
//   rst_in       asynchronous active-low reset
//   left_in      left-channel sample (two's complement)
//   right_in     right-channel sample (two's complement)
//   valid_in     left_in/right_in hold a valid pair
//   ready_out    holding buffer empty; pair accepted on valid_in && ready_out
//   sclk_out     I2S bit clock, clk_in / (2*CLK_DIV)
//   ws_out       I2S word select, 0 = left slot, 1 = right slot
//   sdata_out    I2S serial data, changes on sclk falling edges
//   underrun_out one-cycle pulse when a frame starts with an empty buffer

module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CLK_DIV      = 16,
  parameter int FRAME_BITS   = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    sclk_out,
  output logic                    ws_out,
  output logic                    sdata_out,
  output logic                    underrun_out
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FRAME_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] F_HALF   = FW'(FRAME_BITS / 2);
  localparam logic [FW-1:0] L_LAST   = FW'(SAMPLE_WIDTH);
  localparam logic [FW-1:0] R_FIRST  = FW'(FRAME_BITS / 2 + 1);
  localparam logic [FW-1:0] R_LAST   = FW'(FRAME_BITS / 2 + SAMPLE_WIDTH);

  logic [DW-1:0]           div_q, div_d;
  logic                    sclk_q, sclk_d;
  logic [FW-1:0]           f_q, f_d;
  logic                    ws_q, ws_d;
  logic                    sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] shl_q, shl_d;
  logic [SAMPLE_WIDTH-1:0] shr_q, shr_d;

  logic                    div_wrap;
  logic                    fall_evt;
  logic                    accept;
  logic [FW-1:0]           f_next;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_q       <= '0;
      sclk_q      <= 1'b0;
      f_q         <= '1;
      ws_q        <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shl_q       <= '0;
      shr_q       <= '0;
    end else begin
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      f_q         <= f_d;
      ws_q        <= ws_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
    end
  end

  always_comb begin
    div_wrap    = (div_q == DIV_LAST);
    // A falling sclk edge is the wrap cycle while sclk is currently high.
    fall_evt    = div_wrap && sclk_q;
    accept      = valid_in && !hold_full_q;
    // FRAME_BITS is a power of two, so the natural wrap of f gives mod FRAME_BITS.
    f_next      = f_q + FW'(1);

    div_d       = div_wrap ? '0 : div_q + DW'(1);
    sclk_d      = div_wrap ? ~sclk_q : sclk_q;
    f_d         = f_q;
    ws_d        = ws_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shl_d       = shl_q;
    shr_d       = shr_q;

    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = left_in;
      hold_r_d    = right_in;
    end

    if (fall_evt) begin
      f_d     = f_next;
      ws_d    = (f_next >= F_HALF);
      sdata_d = 1'b0;
      if (f_next == '0) begin
        // Frame load. An accept in this same cycle only fills the buffer
        // (hold_full_q is still 0), so the frame goes out silent.
        if (hold_full_q) begin
          shl_d       = hold_l_q;
          shr_d       = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          shl_d      = '0;
          shr_d      = '0;
          underrun_d = 1'b1;
        end
      end else if (f_next <= L_LAST) begin
        sdata_d = shl_q[SAMPLE_WIDTH-1];
        shl_d   = shl_q << 1;
      end else if ((f_next >= R_FIRST) && (f_next <= R_LAST)) begin
        sdata_d = shr_q[SAMPLE_WIDTH-1];
        shr_d   = shr_q << 1;
      end
    end
  end

  assign ready_out    = !hold_full_q;
  assign sclk_out     = sclk_q;
  assign ws_out       = ws_q;
  assign sdata_out    = sdata_q;
  assign underrun_out = underrun_q;

endmodule
